// File: rtl/fifo_param.sv
// ============================================================================
//  Module   : fifo_param
//  Purpose  : Single-clock parametrised FIFO with fill count, programmable
//             almost flags, sticky error flags and standard/FWFT read modes.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 3,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int                c_DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_DEPTH_CNT = (ADDR_WIDTH+1)'(c_DEPTH);
  localparam logic [ADDR_WIDTH:0] c_AF_CNT    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] c_AE_CNT    = (ADDR_WIDTH+1)'(AE_LEVEL);

  if (AF_LEVEL < 1 || AF_LEVEL > c_DEPTH) begin : g_bad_af
    $error("fifo_param: AF_LEVEL out of range 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > c_DEPTH - 1) begin : g_bad_ae
    $error("fifo_param: AE_LEVEL out of range 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_af;
  logic                  r_ae;
  logic                  r_ovf;
  logic                  r_udf;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [ADDR_WIDTH:0]   w_count_next;

  // Acceptance is judged against the registered flags, so a write at full
  // is rejected even when a read frees a slot on the same edge.
  assign w_wr_acc     = wr_en & ~r_full;
  assign w_rd_acc     = rd_en & ~r_empty;
  assign w_count_next = r_count + {{ADDR_WIDTH{1'b0}}, w_wr_acc}
                                - {{ADDR_WIDTH{1'b0}}, w_rd_acc};

  always_ff @(posedge clk) begin
    if (!rst && w_wr_acc) begin
      r_mem[r_wptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_af    <= 1'b0;
      r_ae    <= 1'b1;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_rd_acc) r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_next;
      r_full  <= (w_count_next == c_DEPTH_CNT);
      r_empty <= (w_count_next == '0);
      r_af    <= (w_count_next >= c_AF_CNT);
      r_ae    <= (w_count_next <= c_AE_CNT);
      // A new error event outranks a simultaneous clear.
      r_ovf   <= (wr_en & r_full)  | (r_ovf & ~clr_err);
      r_udf   <= (rd_en & r_empty) | (r_udf & ~clr_err);
    end
  end

  if (FWFT != 0) begin : g_fwft
    logic r_seen;
    always_ff @(posedge clk) begin
      if (rst)           r_seen <= 1'b0;
      else if (w_wr_acc) r_seen <= 1'b1;
    end
    // Memory is not cleared by reset, so mask the head until a real write.
    assign dout = r_seen ? r_mem[r_rptr] : '0;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] r_dout;
    always_ff @(posedge clk) begin
      if (rst)           r_dout <= '0;
      else if (w_rd_acc) r_dout <= r_mem[r_rptr];
    end
    assign dout = r_dout;
  end

  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule

`default_nettype wire

// File: tb/tb_fifo_param.sv
// ============================================================================
//  Module   : tb_fifo_param
//  Purpose  : Directed bench for fifo_param, standard and FWFT instances.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fifo_param;

  logic       clk = 1'b0;
  logic       r_rst = 1'b1;
  logic       r_wr_en = 1'b0;
  logic       r_rd_en = 1'b0;
  logic       r_clr = 1'b0;
  logic [7:0] r_din = '0;

  logic [7:0] w_a_dout, w_b_dout;
  logic [4:0] w_a_count, w_b_count;
  logic       w_a_full, w_a_empty, w_a_af, w_a_ae, w_a_ovf, w_a_udf;
  logic       w_b_full, w_b_empty, w_b_af, w_b_ae, w_b_ovf, w_b_udf;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fifo_param #(.FWFT(0)) u_std (
    .clk(clk), .rst(r_rst), .wr_en(r_wr_en), .din(r_din), .rd_en(r_rd_en),
    .dout(w_a_dout), .full(w_a_full), .empty(w_a_empty),
    .almost_full(w_a_af), .almost_empty(w_a_ae), .count(w_a_count),
    .overflow(w_a_ovf), .underflow(w_a_udf), .clr_err(r_clr)
  );

  fifo_param #(.FWFT(1)) u_fwft (
    .clk(clk), .rst(r_rst), .wr_en(r_wr_en), .din(r_din), .rd_en(r_rd_en),
    .dout(w_b_dout), .full(w_b_full), .empty(w_b_empty),
    .almost_full(w_b_af), .almost_empty(w_b_ae), .count(w_b_count),
    .overflow(w_b_ovf), .underflow(w_b_udf), .clr_err(r_clr)
  );

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    r_wr_en = 1'b1; r_din = d; r_rd_en = 1'b0;
    step();
    r_wr_en = 1'b0;
  endtask

  task automatic pop();
    r_rd_en = 1'b1; r_wr_en = 1'b0;
    step();
    r_rd_en = 1'b0;
  endtask

  initial begin
    // Reset state
    r_rst = 1'b1; step(); step(); r_rst = 1'b0;
    check_val("rst_count", 32'(w_a_count), 0);
    check_val("rst_empty", 32'(w_a_empty), 1);
    check_val("rst_full",  32'(w_a_full), 0);
    check_val("rst_ae",    32'(w_a_ae), 1);
    check_val("rst_af",    32'(w_a_af), 0);
    check_val("rst_ovf",   32'(w_a_ovf), 0);
    check_val("rst_udf",   32'(w_a_udf), 0);
    check_val("rst_dout_a", 32'(w_a_dout), 0);
    check_val("rst_dout_b", 32'(w_b_dout), 0);

    // Fill 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      push(8'(i));
      check_val("fill_count", 32'(w_a_count), 32'(i));
      check_val("fill_af",    32'(w_a_af), (i >= 12) ? 1 : 0);
      check_val("fill_ae",    32'(w_a_ae), (i <= 3) ? 1 : 0);
      check_val("fill_full",  32'(w_a_full), (i == 16) ? 1 : 0);
      check_val("fill_fwft_head", 32'(w_b_dout), 32'h01);
    end
    push(8'h11);
    check_val("ovf_set",   32'(w_a_ovf), 1);
    check_val("ovf_count", 32'(w_a_count), 16);

    // Drain in order
    for (int i = 0; i < 16; i++) begin
      pop();
      check_val("drain_dout",  32'(w_a_dout), 32'(i + 1));
      check_val("drain_count", 32'(w_a_count), 32'(15 - i));
      check_val("drain_ae",    32'(w_a_ae), (15 - i <= 3) ? 1 : 0);
      check_val("drain_empty", 32'(w_a_empty), (i == 15) ? 1 : 0);
      if (i < 15) check_val("drain_fwft_head", 32'(w_b_dout), 32'(i + 2));
    end
    pop();
    check_val("udf_set",   32'(w_a_udf), 1);
    check_val("udf_dout",  32'(w_a_dout), 32'h10);
    check_val("udf_count", 32'(w_a_count), 0);

    // Clear both sticky flags
    r_clr = 1'b1; step(); r_clr = 1'b0;
    check_val("clr_ovf", 32'(w_a_ovf), 0);
    check_val("clr_udf", 32'(w_a_udf), 0);

    // Simultaneous read/write mid-level
    for (int i = 0; i < 5; i++) push(8'(8'h20 + i));
    r_wr_en = 1'b1; r_rd_en = 1'b1; r_din = 8'h25; step();
    r_wr_en = 1'b0; r_rd_en = 1'b0;
    check_val("sim_mid_count", 32'(w_a_count), 5);
    check_val("sim_mid_dout",  32'(w_a_dout), 32'h20);
    for (int i = 1; i <= 5; i++) begin
      pop();
      check_val("sim_mid_order", 32'(w_a_dout), 32'(8'h20 + i));
    end

    // Simultaneous at full: write lost
    for (int i = 0; i < 16; i++) push(8'(8'h30 + i));
    r_wr_en = 1'b1; r_rd_en = 1'b1; r_din = 8'h99; step();
    r_wr_en = 1'b0; r_rd_en = 1'b0;
    check_val("sim_full_count", 32'(w_a_count), 15);
    check_val("sim_full_ovf",   32'(w_a_ovf), 1);
    check_val("sim_full_dout",  32'(w_a_dout), 32'h30);
    for (int i = 1; i < 16; i++) begin
      pop();
      check_val("sim_full_order", 32'(w_a_dout), 32'(8'h30 + i));
    end
    check_val("sim_full_empty", 32'(w_a_empty), 1);

    // Simultaneous at empty: read rejected
    r_wr_en = 1'b1; r_rd_en = 1'b1; r_din = 8'h77; step();
    r_wr_en = 1'b0; r_rd_en = 1'b0;
    check_val("sim_empty_count", 32'(w_a_count), 1);
    check_val("sim_empty_udf",   32'(w_a_udf), 1);
    check_val("sim_empty_hold",  32'(w_a_dout), 32'h3F);
    check_val("sim_empty_fwft",  32'(w_b_dout), 32'h77);
    pop();
    check_val("sim_empty_rd", 32'(w_a_dout), 32'h77);
    r_clr = 1'b1; step(); r_clr = 1'b0;

    // Wrap-around: 40 words through, level held at 6
    for (int i = 0; i < 6; i++) push(8'(8'h40 + i));
    for (int i = 0; i < 34; i++) begin
      r_wr_en = 1'b1; r_rd_en = 1'b1; r_din = 8'(8'h46 + i); step();
      check_val("wrap_dout",  32'(w_a_dout), 32'(8'h40 + i));
      check_val("wrap_count", 32'(w_a_count), 6);
      check_val("wrap_flags", {28'd0, w_a_full, w_a_empty, w_a_af, w_a_ae}, 0);
    end
    r_wr_en = 1'b0; r_rd_en = 1'b0;
    for (int i = 34; i < 40; i++) begin
      pop();
      check_val("wrap_tail", 32'(w_a_dout), 32'(8'h40 + i));
    end
    check_val("wrap_empty", 32'(w_a_empty), 1);
    check_val("wrap_err", {30'd0, w_a_ovf, w_a_udf}, 0);

    // clr_err with write at full: overflow set wins
    for (int i = 0; i < 16; i++) push(8'(8'h50 + i));
    r_wr_en = 1'b1; r_clr = 1'b1; r_din = 8'hEE; step();
    r_wr_en = 1'b0; r_clr = 1'b0;
    check_val("clr_vs_set_ovf", 32'(w_a_ovf), 1);
    check_val("clr_vs_set_cnt", 32'(w_a_count), 16);

    // Reset mid-operation at count 7
    for (int i = 0; i < 9; i++) pop();
    check_val("pre_rst_count", 32'(w_a_count), 7);
    r_rst = 1'b1; step(); r_rst = 1'b0;
    check_val("mid_rst_count", 32'(w_a_count), 0);
    check_val("mid_rst_empty", 32'(w_a_empty), 1);
    check_val("mid_rst_ovf",   32'(w_a_ovf), 0);
    check_val("mid_rst_dout_a", 32'(w_a_dout), 0);
    check_val("mid_rst_dout_b", 32'(w_b_dout), 0);

    // FWFT behaviour
    push(8'hA5);
    check_val("fwft_empty", 32'(w_b_empty), 0);
    check_val("fwft_first", 32'(w_b_dout), 32'hA5);
    check_val("std_no_read", 32'(w_a_dout), 0);
    push(8'h5A);
    check_val("fwft_hold", 32'(w_b_dout), 32'hA5);
    pop();
    check_val("fwft_next",  32'(w_b_dout), 32'h5A);
    check_val("fwft_count", 32'(w_b_count), 1);
    check_val("std_read",   32'(w_a_dout), 32'hA5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
